rr_bus_controller: RTL
======================

Name: rr_bus_controller

Overview:
- Parametrised successor to the shared-bus controller: arbitrates NUM_DEVICES masters onto one data bus and one control bus, with round-robin fairness, address-decoded slave select and counted bursts.
- Adds a wait-state watchdog and an explicit error report.
- Sits between all bus endpoints (CPU, memory, peripherals) and the shared bus_out/ctrl_out nets.

Parameters:
NUM_DEVICES, 8, number of endpoints (2..16)
BUS_WIDTH, 32, data/address width
CTRL_WIDTH, 8, control word width (>=5)
SEL_BITS, 4, top address bits selecting slave index; remaining low bits form the physical address
TIMEOUT, 255, maximum consecutive wait cycles in a data phase before abort

Ports:
clk  in  1  system clock, all logic posedge
reset  in  1  synchronous, active-high
req  in  NUM_DEVICES  per-device bus request
ack  out  NUM_DEVICES  one-hot grant/select, at most one bit set
ctrl_in  in  NUM_DEVICES*CTRL_WIDTH  flattened per-device control, device i at [i*CTRL_WIDTH +: CTRL_WIDTH]
ctrl_out  out  CTRL_WIDTH  shared control bus
bus_in  in  NUM_DEVICES*BUS_WIDTH  flattened per-device data, device i at [i*BUS_WIDTH +: BUS_WIDTH]
bus_out  out  BUS_WIDTH  shared data/address bus
grant_id  out  clog2(NUM_DEVICES)  index of current master
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse on timeout or bad slave decode

Behaviour:
- Control word layout: bit0 WAIT, bit1 WE, bits[4:2] BURST. Beats per transfer = BURST+1 (1..8).
- Reset: state=IDLE; ack=0, ctrl_out=0, bus_out=0, grant_id=0, busy=0, err=0; rr pointer=NUM_DEVICES-1, so device 0 wins first. Reset mid-transfer aborts with no FINISH cycle and no err.
- Arbitration:
  - Round-robin search starting at pointer+1, wrapping.
  - Pointer updates to the granted index in FINISH only.
  - Requests arriving mid-transfer are ignored until IDLE.
- States:
  - IDLE: outputs zero. Any req -> ACK, latching the winner into master_idx.
  - ACK: ack=onehot(master); ctrl_out=master ctrl; bus_out=master bus. Latch WE and BURST. -> ADDR.
  - ADDR: master drives the virtual address.
    - slave_idx = addr[BUS_WIDTH-1 -: SEL_BITS].
    - bus_out = address with the top SEL_BITS zeroed.
    - If slave_idx>=NUM_DEVICES or slave_idx==master_idx: err pulse next cycle, -> FINISH.
    - Otherwise -> ACK_SLAVE.
  - ACK_SLAVE: ack=onehot(slave); bus_out holds the previous cycle's physical address; ctrl_out={0,BURST,WE,1}. -> DATA.
  - DATA:
    - ack=onehot(slave).
    - Data source = master if WE, else slave; bus_out=source bus; ctrl_out=source ctrl.
    - A beat completes on each cycle where the source WAIT bit=0; the 3-bit beat counter increments.
    - -> FINISH when the final beat completes, or when master req drops (early termination; a beat in the same cycle still counts).
    - Wait counter counts consecutive WAIT=1 cycles and clears on each beat. Reaching TIMEOUT -> FINISH with err pulse.
  - FINISH: ack=0, ctrl_out=0, bus_out=0; pointer update; counters cleared. -> IDLE.
- Minimum transfer = 6 cycles (IDLE..FINISH, single beat, no waits).
- Outputs are Moore-decoded from registered state/indices, except the bus_out/ctrl_out data muxes. err is registered.
- grant_id is valid from ACK through FINISH and holds its last value in IDLE.
- Simultaneous final beat and timeout: beat wins, no err.
- A burst of 8 must not wrap the beat counter.

Decomposition:
- Package bus_ctrl_pkg: control bit positions (WAIT/WE/BURST), state encoding, clog2 helper.
- Sub-module rr_arbiter: NUM_DEVICES-wide round-robin picker with pointer register, update enable and one-hot/index outputs.

Test Plan:
1. Device 3 writes to slave 1 at addr 0x1000_0040, BURST=0, no wait -> ack=0x08 then 0x02; bus_out=0x0000_0040 in ADDR and ACK_SLAVE; ctrl_out=0x03 in ACK_SLAVE; FINISH at cycle 5; err=0.
2. Devices 0, 2 and 5 request continuously -> grant order 0, 2, 5, 0; no device granted twice while another waits.
3. Master 2 reads a 4-beat burst (BURST=3) from slave 6, which asserts WAIT for 2 cycles before beat 2 -> exactly 4 beats observed; DATA lasts 6 cycles; bus_out follows bus_in of device 6.
4. Slave holds WAIT=1 indefinitely with TIMEOUT=255 -> err pulses once 255 cycles into DATA; FINISH then IDLE.
5. Address top nibble 0xF with NUM_DEVICES=8, or slave index equal to master -> err pulse, no slave ack, return to IDLE.
6. reset asserted during DATA of an 8-beat burst -> next cycle all outputs 0, state IDLE, pointer=NUM_DEVICES-1; new req from device 0 is granted normally.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the round-robin bus controller: control word
// field positions, FSM state encoding and a width helper.
package bus_ctrl_pkg;

    localparam int CTRL_WAIT      = 0;
    localparam int CTRL_WE        = 1;
    localparam int CTRL_BURST_LSB = 2;
    localparam int CTRL_BURST_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_ADDR,
        ST_ACK_SLAVE,
        ST_DATA,
        ST_FINISH
    } state_t;

    // Bits needed to index n items, never less than 1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester strictly after the pointer.
module rr_arbiter
    import bus_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  i_req,
    input  logic          i_upd_en,
    input  logic [IW-1:0] i_upd_idx,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any
);

    logic [IW-1:0] r_ptr;
    int            w_cand;
    logic [IW-1:0] w_idx;

    // Pointer only moves when the controller retires a transfer
    always_ff @(posedge clk) begin
        if (reset)         r_ptr <= IW'(N - 1);
        else if (i_upd_en) r_ptr <= i_upd_idx;
    end

    // Search pointer+1 .. pointer+N with wrap, keep the first hit
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = 0;
        w_idx       = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= N) w_cand = w_cand - N;
            w_idx = IW'(w_cand);
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant_idx    = w_idx;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_bus_controller.sv
// Shared-bus controller: round-robin master grant, address-decoded slave
// select, counted bursts with a wait-state watchdog and error pulse.
module rr_bus_controller
    import bus_ctrl_pkg::*;
#(
    parameter int NUM_DEVICES = 8,
    parameter int BUS_WIDTH   = 32,
    parameter int CTRL_WIDTH  = 8,
    parameter int SEL_BITS    = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_DEVICES-1:0]            req,
    output logic [NUM_DEVICES-1:0]            ack,
    input  logic [NUM_DEVICES*CTRL_WIDTH-1:0] ctrl_in,
    output logic [CTRL_WIDTH-1:0]             ctrl_out,
    input  logic [NUM_DEVICES*BUS_WIDTH-1:0]  bus_in,
    output logic [BUS_WIDTH-1:0]              bus_out,
    output logic [clog2(NUM_DEVICES)-1:0]     grant_id,
    output logic                              busy,
    output logic                              err
);

    localparam int IW = clog2(NUM_DEVICES);
    localparam int WW = clog2(TIMEOUT + 1);
    localparam logic [BUS_WIDTH-1:0] PA_MASK = {BUS_WIDTH{1'b1}} >> SEL_BITS;

    state_t                  r_state, w_next;
    logic [IW-1:0]           r_master_idx, r_slave_idx;
    logic [NUM_DEVICES-1:0]  r_master_oh;
    logic                    r_we, r_err;
    logic [2:0]              r_burst, r_beat_cnt;
    logic [WW-1:0]           r_wait_cnt;
    logic [BUS_WIDTH-1:0]    r_paddr;

    logic [NUM_DEVICES-1:0][BUS_WIDTH-1:0]  w_bus;
    logic [NUM_DEVICES-1:0][CTRL_WIDTH-1:0] w_ctrl;
    logic [BUS_WIDTH-1:0]    w_mbus, w_sbus, w_src_bus, w_paddr;
    logic [CTRL_WIDTH-1:0]   w_mctrl, w_sctrl, w_src_ctrl;
    logic [SEL_BITS-1:0]     w_addr_sel;
    logic                    w_bad_sel, w_beat, w_last, w_timeout, w_early;
    logic [NUM_DEVICES-1:0]  w_arb_oh;
    logic [IW-1:0]           w_arb_idx;
    logic                    w_arb_any;

    rr_arbiter #(.N(NUM_DEVICES), .IW(IW)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req),
        .i_upd_en    (r_state == ST_FINISH),
        .i_upd_idx   (r_master_idx),
        .o_grant     (w_arb_oh),
        .o_grant_idx (w_arb_idx),
        .o_any       (w_arb_any)
    );

    assign w_bus      = bus_in;
    assign w_ctrl     = ctrl_in;
    assign w_mbus     = w_bus[r_master_idx];
    assign w_mctrl    = w_ctrl[r_master_idx];
    assign w_sbus     = w_bus[r_slave_idx];
    assign w_sctrl    = w_ctrl[r_slave_idx];
    assign w_src_bus  = r_we ? w_mbus  : w_sbus;
    assign w_src_ctrl = r_we ? w_mctrl : w_sctrl;

    assign w_addr_sel = w_mbus[BUS_WIDTH-1 -: SEL_BITS];
    assign w_paddr    = w_mbus & PA_MASK;
    assign w_bad_sel  = (int'(w_addr_sel) >= NUM_DEVICES) ||
                        (int'(w_addr_sel) == int'(r_master_idx));

    // Beat on WAIT=0; a final beat can never coincide with a timeout
    assign w_beat    = ~w_src_ctrl[CTRL_WAIT];
    assign w_last    = w_beat && (r_beat_cnt == r_burst);
    assign w_timeout = !w_beat && (r_wait_cnt == WW'(TIMEOUT - 1));
    assign w_early   = !req[r_master_idx];

    assign grant_id = r_master_idx;
    assign busy     = (r_state != ST_IDLE);
    assign err      = r_err;

    // State, latched transfer attributes and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_master_idx <= '0;
            r_master_oh  <= '0;
            r_slave_idx  <= '0;
            r_we         <= 1'b0;
            r_burst      <= '0;
            r_beat_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_paddr      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_arb_any) begin
                    r_master_idx <= w_arb_idx;
                    r_master_oh  <= w_arb_oh;
                end
                ST_ACK: begin
                    r_we    <= w_mctrl[CTRL_WE];
                    r_burst <= w_mctrl[CTRL_BURST_LSB +: CTRL_BURST_W];
                end
                ST_ADDR: begin
                    r_paddr     <= w_paddr;
                    r_slave_idx <= IW'(w_addr_sel);
                    if (w_bad_sel) r_err <= 1'b1;
                end
                ST_DATA: begin
                    if (w_beat) begin
                        r_wait_cnt <= '0;
                        if (!w_last) r_beat_cnt <= r_beat_cnt + 3'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_beat_cnt <= '0;
                    r_wait_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next state and Moore-decoded grant/select with bus/control muxes
    always_comb begin
        w_next   = r_state;
        ack      = '0;
        ctrl_out = '0;
        bus_out  = '0;
        case (r_state)
            ST_IDLE: if (w_arb_any) w_next = ST_ACK;
            ST_ACK: begin
                ack      = r_master_oh;
                ctrl_out = w_mctrl;
                bus_out  = w_mbus;
                w_next   = ST_ADDR;
            end
            ST_ADDR: begin
                ack      = r_master_oh;
                ctrl_out = w_mctrl;
                bus_out  = w_paddr;
                w_next   = w_bad_sel ? ST_FINISH : ST_ACK_SLAVE;
            end
            ST_ACK_SLAVE: begin
                ack      = NUM_DEVICES'(1) << r_slave_idx;
                ctrl_out = CTRL_WIDTH'({r_burst, r_we, 1'b1});
                bus_out  = r_paddr;
                w_next   = ST_DATA;
            end
            ST_DATA: begin
                ack      = NUM_DEVICES'(1) << r_slave_idx;
                ctrl_out = w_src_ctrl;
                bus_out  = w_src_bus;
                if (w_last || w_early || w_timeout) w_next = ST_FINISH;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

endmodule
